spi_master: RTL
===============

# spi_master

SPI controller (master) for the on-board register interface: drives `sclk`, `cs` and `mosi` and samples `miso`, so a host-side state machine can read and write the FPGA's SPI peripheral register file. Mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit frames. Multi-byte transactions keep `cs` low between bytes, so the peripheral's byte counter and register sequencing see one contiguous transfer.

## Interface
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles; must be ≥2.
- `CS_SETUP`, 4: `clk` cycles from `cs` falling to the start of the first `sclk` low phase.
- `CS_HOLD`, 2: `clk` cycles `cs` stays low after the last `sclk` fall of the final byte.
- `CS_GAP`, 4: minimum `clk` cycles `cs` stays high before the next accept.

- `clk` input 1: system clock; the only clock.
- `reset` input 1: synchronous, active-high.
- `txData` input 8: byte to send.
- `txValid` input 1: `txData` and `keepCs` are valid.
- `keepCs` input 1: keep `cs` low after this byte for a following byte.
- `txReady` output 1: accept on `txValid & txReady`.
- `rxData` output 8: byte received on `miso`; stable until the next `rxValid`.
- `rxValid` output 1: one-cycle pulse; `rxData` is updated.
- `busy` output 1: high in every state except IDLE.
- `sclk` output 1: SPI clock.
- `cs` output 1: chip select, active low.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in.

## Operation
- **Reset values:** `cs`=1, `sclk`=0, `mosi`=0, `rxValid`=0, `rxData`=0, `busy`=0. State is IDLE. `txReady`=0 while `reset` is high.
- **States:** IDLE, SETUP, SHIFT_LO, SHIFT_HI, WAIT_NEXT, HOLD, GAP.
- **IDLE:** `txReady`=1. On accept:
  - latch `txData` into the shift register and latch `keepCs`;
  - go to SETUP with `cs`=0 and `mosi`=`txData[7]`.
- **SETUP:** lasts `CS_SETUP` cycles, then SHIFT_LO.
- **SHIFT_LO:** `sclk`=0 for `CLK_DIV` cycles, then SHIFT_HI.
- **SHIFT_HI:** `sclk`=1 for `CLK_DIV` cycles.
  - On the cycle `sclk` rises, register `miso` into the receive shift register LSB.
  - On leaving SHIFT_HI, `sclk` falls.
  - If fewer than 8 bits are done, shift the next bit onto `mosi` and go to SHIFT_LO.
- **After the 8th bit:** `rxValid` pulses on the cycle `sclk` falls. Next state is WAIT_NEXT if the latched `keepCs`=1, else HOLD.
- **WAIT_NEXT:** `cs`=0, `sclk`=0, `txReady`=1, `mosi` holds its last value.
  - On accept: load the new byte, `mosi`=bit 7, go directly to SHIFT_LO (no SETUP).
  - Waits indefinitely.
- **HOLD:** `cs`=0 for `CS_HOLD` cycles, then `cs`=1, `mosi`=0, go to GAP.
- **GAP:** `cs`=1 for `CS_GAP` cycles, then IDLE.
- `txValid` outside IDLE or WAIT_NEXT is ignored (`txReady`=0); the bench holds the byte.
- Bit counter is 3 bits; the byte ends when the counter wraps 7→0 on `sclk` fall.
- **Reset mid-operation:** all outputs take reset values the next cycle. No `rxValid`, no partial `rxData` update.

## Timing
- Accept in IDLE at cycle T:
  - `cs` falls at T+1.
  - First `sclk` rise at T+1+`CS_SETUP`+`CLK_DIV`.
  - Rises are spaced 2·`CLK_DIV` cycles apart.
  - Last fall and `rxValid` at T+1+`CS_SETUP`+16·`CLK_DIV`; T+69 with defaults.
- Accept in WAIT_NEXT at cycle U: first rise at U+1+`CLK_DIV`; `rxValid` at U+1+16·`CLK_DIV`.
- `mosi` changes only on `sclk` fall, or on entry to SETUP/SHIFT_LO after an accept. It is stable ≥`CLK_DIV` cycles before each rise.
- The peripheral oversamples `sclk` with its own `clk`, so `CLK_DIV`≥2 at equal clock rates.
- `cs` high time between transactions is ≥`CS_GAP` cycles.

## Structure
- Shared package `spi_pkg`:
  - state enum type;
  - `SPI_FRAME_BITS`=8;
  - default values of `CLK_DIV`, `CS_SETUP`, `CS_HOLD`, `CS_GAP`.
- One sub-module, `spi_sclk_gen`:
  - `CLK_DIV` half-period counter with `clk`/`reset`/`run` inputs;
  - outputs `sclk` level plus one-cycle `rise`/`fall` strobes;
  - restarts in low phase when `run` rises.
- The top FSM owns the shift registers, bit counter, SETUP/HOLD/GAP counter and handshake.

## Test plan
- **Loopback** (`miso`=`mosi`), send 0xA5 with `keepCs`=0 at T → `rxData`=0xA5 and `rxValid` at T+69. Exactly 8 rises. `cs` high from T+72; `txReady` high again at T+76.
- **Peripheral model** shifting out 0x3C while host sends 0xC3 → `rxData`=0x3C; model captures 0xC3.
- **Two bytes:** 0x12 with `keepCs`=1, then 0x34 with `keepCs`=0 → `cs` low continuously, 16 rises, two `rxValid` pulses with 0x12 then 0x34 (loopback). No SETUP before the 2nd byte.
- **Reset pulse** one cycle after the 3rd rise → next cycle `cs`=1, `sclk`=0, `mosi`=0, no `rxValid`. A following 0x5A transfer completes correctly.
- **Stall in WAIT_NEXT** for 100 cycles → `cs`=0, `sclk`=0, `txReady`=1 throughout, no edges.
- **`txValid` asserted mid-byte** → `txReady`=0 and no accept until IDLE or WAIT_NEXT; first byte's `rxData` is unaffected.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master and its sclk generator.
// Default timing gives rxValid 69 clk cycles after an IDLE accept.
package spi_pkg;

    localparam int unsigned SPI_FRAME_BITS   = 8;
    localparam int unsigned SPI_CLK_DIV_DEF  = 4;
    localparam int unsigned SPI_CS_SETUP_DEF = 4;
    localparam int unsigned SPI_CS_HOLD_DEF  = 2;
    localparam int unsigned SPI_CS_GAP_DEF   = 4;
    localparam int unsigned SPI_TMR_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_WAIT_NEXT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    // Chip select is driven low in every state between accept and the end of HOLD.
    function automatic logic spi_cs_active(input spi_state_e s);
        return (s == ST_SETUP) || (s == ST_SHIFT_LO) || (s == ST_SHIFT_HI) ||
               (s == ST_WAIT_NEXT) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// sclk generator: CLK_DIV-cycle half periods, low phase first whenever run is raised.
// rise_o/fall_o flag the last cycle of a phase, i.e. sclk_o toggles at the next edge.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          toggle;

    assign toggle = run_i && (cnt_q == CNT_LAST);
    assign rise_o = toggle && !sclk_q;
    assign fall_o = toggle && sclk_q;
    assign sclk_o = sclk_q;

    // Holding the counter cleared while idle makes every run start a fresh low phase.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!run_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (toggle) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 MSB-first SPI master; rxValid 1+CS_SETUP+16*CLK_DIV cycles after an IDLE accept.
// Backpressure: txReady only in IDLE/WAIT_NEXT; keepCs holds cs low waiting for the next byte.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = SPI_CLK_DIV_DEF,
    parameter int unsigned CS_SETUP = SPI_CS_SETUP_DEF,
    parameter int unsigned CS_HOLD  = SPI_CS_HOLD_DEF,
    parameter int unsigned CS_GAP   = SPI_CS_GAP_DEF
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [SPI_FRAME_BITS-1:0] tx_data_i,
    input  logic                      tx_valid_i,
    input  logic                      keep_cs_i,
    output logic                      tx_ready_o,
    output logic [SPI_FRAME_BITS-1:0] rx_data_o,
    output logic                      rx_valid_o,
    output logic                      busy_o,
    output logic                      sclk_o,
    output logic                      cs_o,
    output logic                      mosi_o,
    input  logic                      miso_i
);

    localparam logic [SPI_TMR_W-1:0] SETUP_LAST = SPI_TMR_W'(CS_SETUP - 1);
    // HOLD also spans the cycle in which the last sclk fall appears, hence no -1.
    localparam logic [SPI_TMR_W-1:0] HOLD_LAST  = SPI_TMR_W'(CS_HOLD);
    localparam logic [SPI_TMR_W-1:0] GAP_LAST   = SPI_TMR_W'(CS_GAP - 1);

    spi_state_e                state_q, state_d;
    logic [SPI_FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
    logic [SPI_FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [SPI_FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      keep_q, keep_d;
    logic                      cs_q, cs_d;
    logic [2:0]                bit_q, bit_d;
    logic [SPI_TMR_W-1:0]      tmr_q, tmr_d;

    logic sclk_run;
    logic sclk_rise;
    logic sclk_fall;
    logic accept;

    assign sclk_run   = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
    assign tx_ready_o = !reset_i && ((state_q == ST_IDLE) || (state_q == ST_WAIT_NEXT));
    assign accept     = tx_valid_i && tx_ready_o;
    assign busy_o     = (state_q != ST_IDLE);
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign cs_o       = cs_q;
    assign mosi_o     = tx_sr_q[SPI_FRAME_BITS-1];

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .run_i   (sclk_run),
        .sclk_o  (sclk_o),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        keep_d     = keep_q;
        bit_d      = bit_q;
        tmr_d      = tmr_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_sr_d = tx_data_i;
                    keep_d  = keep_cs_i;
                    bit_d   = '0;
                    tmr_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_SHIFT_LO;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (sclk_rise) begin
                    rx_sr_d = {rx_sr_q[SPI_FRAME_BITS-2:0], miso_i};
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (sclk_fall) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        // Last bit stays on mosi; the frame is complete.
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                        tmr_d      = '0;
                        state_d    = keep_q ? ST_WAIT_NEXT : ST_HOLD;
                    end else begin
                        tx_sr_d = {tx_sr_q[SPI_FRAME_BITS-2:0], 1'b0};
                        state_d = ST_SHIFT_LO;
                    end
                end
            end
            ST_WAIT_NEXT: begin
                if (accept) begin
                    tx_sr_d = tx_data_i;
                    keep_d  = keep_cs_i;
                    bit_d   = '0;
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    tmr_d   = '0;
                    tx_sr_d = '0;
                    state_d = ST_GAP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cs_d = !spi_cs_active(state_d);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            keep_q     <= 1'b0;
            cs_q       <= 1'b1;
            bit_q      <= '0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            keep_q     <= keep_d;
            cs_q       <= cs_d;
            bit_q      <= bit_d;
            tmr_q      <= tmr_d;
        end
    end

endmodule
